// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-source result handshakes in, one register-file write port out.
interface wb_arbiter_if #(
  parameter int unsigned NSRC   = 3,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned NREG = 2**REG_W;

  logic [NSRC-1:0]        src_valid;
  logic [NSRC-1:0]        src_ready;
  logic [NSRC*REG_W-1:0]  src_rd;
  logic [NSRC*WORD_W-1:0] src_wdat;
  logic                   hold;
  logic                   wen;
  logic [REG_W-1:0]       wsel;
  logic [WORD_W-1:0]      wdat;
  logic [NREG-1:0]        pending_mask;

  // Producer / control side: result sources, halt control and the issue scoreboard.
  modport master (
    output src_valid, src_rd, src_wdat, hold,
    input  src_ready, wen, wsel, wdat, pending_mask
  );

  // Arbiter side.
  modport slave (
    input  src_valid, src_rd, src_wdat, hold,
    output src_ready, wen, wsel, wdat, pending_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one skid buffer per result source feeding a
// registered register-file write port, plus a pending-write mask for hazard checks.
module wb_arbiter #(
  parameter int unsigned NSRC   = 3,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WORD_W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned NREG  = 2**REG_W;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [NSRC-1:0]   buf_valid;
  logic [REG_W-1:0]  buf_rd  [NSRC];
  logic [WORD_W-1:0] buf_dat [NSRC];
  ptr_t              rr_ptr;
  logic              wen_q;
  logic [REG_W-1:0]  wsel_q;
  logic [WORD_W-1:0] wdat_q;

  logic [REG_W-1:0]  in_rd  [NSRC];
  logic [WORD_W-1:0] in_dat [NSRC];
  logic [NSRC-1:0]   grant;
  logic [NSRC-1:0]   ready;
  logic [NSRC-1:0]   accept;
  logic              grant_any;
  ptr_t              grant_idx;
  ptr_t              rr_ptr_nxt;
  ptr_t              cand_idx;
  int unsigned       cand;
  logic [NREG-1:0]   pend;

  // Unpack the flat source buses.
  always_comb begin
    for (int i = 0; i < int'(NSRC); i++) begin
      in_rd[i]  = bus.src_rd[i*REG_W +: REG_W];
      in_dat[i] = bus.src_wdat[i*WORD_W +: WORD_W];
    end
  end

  // Round-robin search starting at rr_ptr; first full buffer wins unless held.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned j = 0; j < NSRC; j++) begin
      cand = 32'(rr_ptr) + j;
      if (cand >= NSRC) cand = cand - NSRC;
      cand_idx = PTR_W'(cand);
      if (!grant_any && !bus.hold && buf_valid[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_any       = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_any) begin
      if (grant_idx == PTR_W'(NSRC - 1)) rr_ptr_nxt = '0;
      else                               rr_ptr_nxt = ptr_t'(grant_idx + 1'b1);
    end
  end

  // A buffer being drained this cycle can take a new result on the same edge.
  always_comb begin
    ready  = '0;
    accept = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      ready[i]  = !buf_valid[i] || grant[i];
      accept[i] = bus.src_valid[i] && ready[i] && (in_rd[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      buf_valid <= '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        buf_rd[i]  <= '0;
        buf_dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_rd[i]    <= in_rd[i];
          buf_dat[i]   <= in_dat[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Registered write port; index and data hold their last value when idle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr <= '0;
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      wen_q  <= grant_any;
      if (grant_any) begin
        wsel_q <= buf_rd[grant_idx];
        wdat_q <= buf_dat[grant_idx];
      end
    end
  end

  // Every in-flight destination: buffered results plus the write on the port.
  always_comb begin
    pend = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (buf_valid[i]) pend[buf_rd[i]] = 1'b1;
    end
    if (wen_q) pend[wsel_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.src_ready    = ready;
  assign bus.wen          = wen_q;
  assign bus.wsel         = wsel_q;
  assign bus.wdat         = wdat_q;
  assign bus.pending_mask = pend;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!nrst) $onehot0(grant));
  a_no_grant_on_hold : assert property (@(posedge clk) disable iff (!nrst) bus.hold |-> grant == '0);
  a_no_r0_buffered : assert property (@(posedge clk) disable iff (!nrst)
                                      !(bus.wen && bus.wsel == '0));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed vectors covering latency,
// round-robin order, streaming, rd=0 discard, hold and async reset.
module tb_wb_arbiter;
  localparam int unsigned NSRC   = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WORD_W = 32;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  wb_arbiter_if #(.NSRC(NSRC), .REG_W(REG_W), .WORD_W(WORD_W)) bus ();

  wb_arbiter #(.NSRC(NSRC), .REG_W(REG_W), .WORD_W(WORD_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [REG_W-1:0] rd,
                         input logic [WORD_W-1:0] d);
    bus.src_valid[i]                 = v;
    bus.src_rd[i*REG_W +: REG_W]     = rd;
    bus.src_wdat[i*WORD_W +: WORD_W] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < int'(NSRC); i++) set_src(i, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    idle_all();
    bus.hold = 1'b0;
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
    check("rst_wen", 64'(bus.wen), 64'd0);
    check("rst_wsel", 64'(bus.wsel), 64'd0);
    check("rst_wdat", 64'(bus.wdat), 64'd0);
    check("rst_pend", 64'(bus.pending_mask), 64'd0);
    check("rst_ready", 64'(bus.src_ready), 64'h7);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    bus.hold = 1'b0;
    idle_all();
    do_reset();

    // Single result: two-cycle latency to the write port.
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
    check("t1_ready0", 64'(bus.src_ready[0]), 64'd1);
    step();
    idle_all();
    check("t1_pend_buf", 64'(bus.pending_mask), 64'h20);
    check("t1_wen_early", 64'(bus.wen), 64'd0);
    step();
    check("t1_wen", 64'(bus.wen), 64'd1);
    check("t1_wsel", 64'(bus.wsel), 64'd5);
    check("t1_wdat", 64'(bus.wdat), 64'hDEADBEEF);
    check("t1_pend_out", 64'(bus.pending_mask), 64'h20);
    step();
    check("t1_wen_off", 64'(bus.wen), 64'd0);
    check("t1_pend_clr", 64'(bus.pending_mask), 64'd0);
    check("t1_wsel_hold", 64'(bus.wsel), 64'd5);

    // All three sources at once from rr_ptr=0.
    do_reset();
    set_src(0, 1'b1, 5'd1, 32'h11);
    set_src(1, 1'b1, 5'd2, 32'h22);
    set_src(2, 1'b1, 5'd3, 32'h33);
    check("t2_ready", 64'(bus.src_ready), 64'h7);
    step();
    idle_all();
    check("t2_pend0", 64'(bus.pending_mask), 64'hE);
    check("t2_wen0", 64'(bus.wen), 64'd0);
    step();
    check("t2_sel1", 64'(bus.wsel), 64'd1);
    check("t2_dat1", 64'(bus.wdat), 64'h11);
    check("t2_pend1", 64'(bus.pending_mask), 64'hE);
    step();
    check("t2_sel2", 64'(bus.wsel), 64'd2);
    check("t2_dat2", 64'(bus.wdat), 64'h22);
    check("t2_pend2", 64'(bus.pending_mask), 64'hC);
    step();
    check("t2_sel3", 64'(bus.wsel), 64'd3);
    check("t2_dat3", 64'(bus.wdat), 64'h33);
    check("t2_wen3", 64'(bus.wen), 64'd1);
    check("t2_pend3", 64'(bus.pending_mask), 64'h8);
    step();
    check("t2_wen_off", 64'(bus.wen), 64'd0);
    check("t2_pend_clr", 64'(bus.pending_mask), 64'd0);

    // src1 streaming rd=1..8, one write per cycle after the fill.
    for (int k = 1; k <= 8; k++) begin
      set_src(1, 1'b1, REG_W'(k), 32'h100 + 32'(k));
      check($sformatf("t3_ready_%0d", k), 64'(bus.src_ready[1]), 64'd1);
      step();
      if (k >= 2) begin
        check($sformatf("t3_wen_%0d", k), 64'(bus.wen), 64'd1);
        check($sformatf("t3_sel_%0d", k), 64'(bus.wsel), 64'(k - 1));
        check($sformatf("t3_dat_%0d", k), 64'(bus.wdat), 64'h100 + 64'(k - 1));
      end else begin
        check("t3_wen_fill", 64'(bus.wen), 64'd0);
      end
    end
    idle_all();
    step();
    check("t3_sel_last", 64'(bus.wsel), 64'd8);
    check("t3_dat_last", 64'(bus.wdat), 64'h108);
    step();
    check("t3_wen_off", 64'(bus.wen), 64'd0);

    // rd=0 completes the handshake but never reaches the port.
    set_src(2, 1'b1, 5'd0, 32'h55);
    check("t4_ready2", 64'(bus.src_ready[2]), 64'd1);
    step();
    idle_all();
    check("t4_pend", 64'(bus.pending_mask), 64'd0);
    check("t4_ready", 64'(bus.src_ready), 64'h7);
    step();
    check("t4_wen", 64'(bus.wen), 64'd0);
    check("t4_pend2", 64'(bus.pending_mask), 64'd0);

    // Hold with two buffers full; rr_ptr sits at 2 so src0 drains first.
    set_src(0, 1'b1, 5'd4, 32'h44);
    set_src(1, 1'b1, 5'd6, 32'h66);
    bus.hold = 1'b1;
    step();
    idle_all();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t5_wen_%0d", c), 64'(bus.wen), 64'd0);
      check($sformatf("t5_ready_%0d", c), 64'(bus.src_ready), 64'h4);
      check($sformatf("t5_pend_%0d", c), 64'(bus.pending_mask), 64'h50);
      step();
    end
    bus.hold = 1'b0;
    step();
    check("t5_sel_a", 64'(bus.wsel), 64'd4);
    check("t5_dat_a", 64'(bus.wdat), 64'h44);
    step();
    check("t5_sel_b", 64'(bus.wsel), 64'd6);
    check("t5_dat_b", 64'(bus.wdat), 64'h66);
    step();
    check("t5_wen_off", 64'(bus.wen), 64'd0);

    // Async reset while two buffers are full and a write is on the port.
    set_src(0, 1'b1, 5'd7, 32'h77);
    set_src(1, 1'b1, 5'd9, 32'h99);
    set_src(2, 1'b1, 5'd10, 32'hAA);
    step();
    idle_all();
    step();
    check("t6_wen_pre", 64'(bus.wen), 64'd1);
    check("t6_pend_pre", 64'(bus.pending_mask), 64'h680);
    #2;
    nrst = 1'b0;
    #1;
    check("t6_wen_async", 64'(bus.wen), 64'd0);
    check("t6_wsel_async", 64'(bus.wsel), 64'd0);
    check("t6_wdat_async", 64'(bus.wdat), 64'd0);
    check("t6_pend_async", 64'(bus.pending_mask), 64'd0);
    check("t6_ready_async", 64'(bus.src_ready), 64'h7);
    #2;
    nrst = 1'b1;
    step();
    step();
    check("t6_wen_post", 64'(bus.wen), 64'd0);
    check("t6_pend_post", 64'(bus.pending_mask), 64'd0);
    check("t6_ready_post", 64'(bus.src_ready), 64'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter that drives the single register-file write port (wen/wsel/wdat) from NSRC independent result producers: ALU pipe, load/store unit and MUL/DIV unit.
- Each source has a valid/ready handshake and a one-entry skid buffer.
- Arbitration is round-robin; the write port is registered.
- Exports a pending-write mask so the issue scoreboard can detect RAW/WAW hazards on in-flight results.

Parameters:
- NSRC, 3, number of result sources (2..4).
- REG_W, 5, register index width (32 architectural registers).
- WORD_W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- src_valid  in  NSRC  source i presents a result.
- src_ready  out  NSRC  source i result accepted this cycle when valid&ready.
- src_rd  in  NSRC*REG_W  destination register; source i at [i*REG_W +: REG_W].
- src_wdat  in  NSRC*WORD_W  result data; source i at [i*WORD_W +: WORD_W].
- hold  in  1  freeze writeback (debug halt); no grants while high.
- wen  out  1  register-file write enable.
- wsel  out  REG_W  register-file write index.
- wdat  out  WORD_W  register-file write data.
- pending_mask  out  2**REG_W  bit r set while a write to r is buffered or on the output register.

Behaviour:
- Reset (async, nrst=0):
  - all buffers empty; rr_ptr=0; wen=0, wsel=0, wdat=0.
  - pending_mask=0; src_ready = all ones once buffers are empty.
  - Reset mid-operation discards all buffered results without writing them.
- Skid buffer i:
  - Holds buf_valid[i], buf_rd[i], buf_dat[i].
  - Accept = src_valid[i] & src_ready[i] & src_rd[i]!=0 → buffer loads at the clock edge.
  - Accept with rd==0: handshake completes (ready honoured), the result is discarded, and the buffer is not loaded.
- Ready rule:
  - src_ready[i] = !buf_valid[i] | grant[i].
  - Depends only on registered state and hold; there is no combinational path from src_valid.
  - This allows drain and refill of the same buffer in the same cycle, giving full throughput of 1 result/cycle/source.
- Arbitration (combinational, every cycle):
  - Candidates are sources with buf_valid=1; none are candidates when hold=1.
  - Search order is rr_ptr, rr_ptr+1, …, wrapping mod NSRC; the first candidate found gets the grant. At most one grant per cycle.
  - On a grant to k: rr_ptr ← (k+1) mod NSRC. With no grant, rr_ptr is unchanged.
- Output register:
  - On a grant to k: next cycle wen=1, wsel=buf_rd[k], wdat=buf_dat[k], and buf_valid[k] clears unless it is refilled the same edge.
  - With no grant: next cycle wen=0; wsel/wdat hold their last values.
- Latency:
  - Accept at edge N → earliest grant in cycle N+1 → wen high in cycle N+2. The register file commits at edge N+2.
- pending_mask:
  - Equals the OR over i of onehot(buf_rd[i]) where buf_valid[i], OR onehot(wsel) when wen=1. Bit 0 is always 0.
  - Combinational from registered state.
- Ordering:
  - The issue stage never has two outstanding writes to the same rd across sources; it uses pending_mask to enforce this.
  - The arbiter does not reorder within a source; cross-source order is round-robin only.
- hold:
  - Grants are blocked, so wen=0 from the next cycle.
  - Buffers retain contents; src_ready = !buf_valid.
  - Deasserting hold resumes arbitration from the current rr_ptr.
- Simultaneous events:
  - All sources valid with empty buffers: all are accepted in the same cycle.
  - Writes then emerge one per cycle in round-robin order starting at rr_ptr.

Test Plan:
- After reset, src0 valid rd=5 data=0xDEADBEEF (one cycle) → src_ready[0]=1 at accept; pending_mask[5]=1 from the next cycle; wen=1, wsel=5, wdat=0xDEADBEEF exactly two cycles after accept; pending_mask=0 the cycle after that.
- All three sources valid in one cycle (rd=1,2,3, data=0x11,0x22,0x33), rr_ptr=0 → writes on three consecutive cycles in order rd1, rd2, rd3; rr_ptr ends at 0; no data loss.
- src1 held valid continuously with incrementing rd=1..8 while src0 and src2 are idle → one write per cycle after 2-cycle fill; src_ready[1] stays 1 throughout.
- src2 valid rd=0 data=0x55 → handshake completes; buffer never fills; wen stays 0; pending_mask stays 0.
- Buffers loaded (rd=4 on src0, rd=6 on src1), then hold=1 for 5 cycles → wen=0 for all 5 cycles; src_ready=3'b100; pending_mask has bits 4 and 6 set; after release, writes rd4 then rd6.
- nrst pulsed low while two buffers are full and wen=1 → outputs are 0 asynchronously; after release no pending write appears and src_ready returns to all ones.
